// File: rtl/sipo_rx_pkg.sv
// ============================================================================
// sipo_rx_pkg : constants and types shared by the 4-bit serial link endpoints
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package sipo_rx_pkg;

  // Bit-order encoding, shared with the PISO transmitter.
  localparam int SIPO_MSB_FIRST = 1;
  localparam int SIPO_LSB_FIRST = 0;

  // Default link word width.
  localparam int LINK_W = 4;

  // Receiver framing state. IDLE means the bit counter is at zero.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } sipo_state_e;

endpackage : sipo_rx_pkg

`default_nettype wire

// File: rtl/sipo_rx_if.sv
// ============================================================================
// sipo_rx_if : serial input and parallel valid/ready output of sipo_rx
// Revision   : 1.0  initial release
// ============================================================================
`default_nettype none

interface sipo_rx_if
  import sipo_rx_pkg::*;
#(
  parameter int WIDTH = LINK_W
) ();

  logic             in;
  logic             in_valid;
  logic             sync;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             out_ready;
  logic             overrun;
  logic             clr_ovr;
  logic             busy;

  // Upstream link driver and parallel consumer.
  modport master (
    output in,
    output in_valid,
    output sync,
    output out_ready,
    output clr_ovr,
    input  out,
    input  out_valid,
    input  overrun,
    input  busy
  );

  // The deserializer itself.
  modport slave (
    input  in,
    input  in_valid,
    input  sync,
    input  out_ready,
    input  clr_ovr,
    output out,
    output out_valid,
    output overrun,
    output busy
  );

endinterface : sipo_rx_if

`default_nettype wire

// File: rtl/sipo_rx_outreg.sv
// ============================================================================
// sipo_outreg : one-entry valid/ready holding register with sticky overrun
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module sipo_outreg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] word,
  input  logic             word_valid,
  input  logic             out_ready,
  input  logic             clr_ovr,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             overrun
);

  logic consume;
  logic load;
  logic drop;

  // A full register can still take a new word if it is drained the same cycle.
  assign consume = out_valid & out_ready;
  assign load    = word_valid & (~out_valid | out_ready);
  assign drop    = word_valid & ~load;

  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (load) begin
        out       <= word;
        out_valid <= 1'b1;
      end else if (consume) begin
        out_valid <= 1'b0;
      end

      // Set has priority over clear.
      if (drop) begin
        overrun <= 1'b1;
      end else if (clr_ovr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule : sipo_outreg

`default_nettype wire

// File: rtl/sipo_rx.sv
// ============================================================================
// sipo_rx : serial-in parallel-out deserializer, receive end of the PISO link
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module sipo_rx
  import sipo_rx_pkg::*;
#(
  parameter int WIDTH     = LINK_W,          // must be >= 2
  parameter int MSB_FIRST = SIPO_MSB_FIRST
) (
  input  logic     clk,
  input  logic     rst,
  sipo_rx_if.slave bus
);

  localparam int            CW        = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST  = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  sipo_state_e      state;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] sh_shifted;
  logic [WIDTH-1:0] sh_nxt;
  logic             last_bit;
  logic             word_done;

  generate
    if (MSB_FIRST == SIPO_MSB_FIRST) begin : g_msb_first
      assign sh_shifted = {sh[WIDTH-2:0], bus.in};
    end else begin : g_lsb_first
      assign sh_shifted = {bus.in, sh[WIDTH-1:1]};
    end
  endgenerate

  assign last_bit = (cnt == CNT_LAST);

  always_comb begin
    cnt_nxt   = cnt;
    sh_nxt    = sh;
    word_done = 1'b0;

    if (bus.in_valid) begin
      sh_nxt = sh_shifted;
    end

    // sync realigns the frame; a bit arriving with it starts the new word.
    if (bus.sync) begin
      cnt_nxt = bus.in_valid ? CNT_ONE : '0;
    end else if (bus.in_valid) begin
      if (last_bit) begin
        cnt_nxt   = '0;
        word_done = 1'b1;
      end else begin
        cnt_nxt = cnt + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      sh    <= '0;
    end else begin
      cnt <= cnt_nxt;
      sh  <= sh_nxt;
      case (state)
        ST_IDLE: begin
          if (cnt_nxt != '0) begin
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (cnt_nxt == '0) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = (state == ST_SHIFT);

  sipo_outreg #(
    .WIDTH (WIDTH)
  ) u_outreg (
    .clk        (clk),
    .rst        (rst),
    .word       (sh_shifted),
    .word_valid (word_done),
    .out_ready  (bus.out_ready),
    .clr_ovr    (bus.clr_ovr),
    .out        (bus.out),
    .out_valid  (bus.out_valid),
    .overrun    (bus.overrun)
  );

endmodule : sipo_rx

`default_nettype wire
